pack_collect_fifo: RTL
======================

# pack_collect_fifo

Parametrised successor to the single-frame packet collector. It sits between `traceIF` and the packet processor, and pulls 1/2/4-bit trace elements. It locks onto the TPIU full sync word and assembles 16-byte TPIU frames into a `DEPTH`-frame FIFO, so that slow readers no longer stall or lose data silently. It adds sync-loss handling, width-change recovery, and a sticky overflow count.

## Interface
- `DEPTH`, 4: frames buffered; power of two, ≥2.
- `SYNC_TIMEOUT`, 0: consecutive frames without a sync word before `sync` drops; 0 disables.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-low.
- `width` in 2: trace port width. 00=1 bit, 01=2 bits, 10/11=4 bits.
- `TraceIn` in 4: trace element; low `width` bits valid.
- `TraceAvail` in 1: an element is available.
- `TraceNext` out 1: one-cycle strobe that consumes `TraceIn`.
- `sync` out 1: aligned to the frame boundary.
- `PacketAvail` out 1: FIFO holds ≥1 frame.
- `PacketNext` in 1: pop a frame into the output register.
- `PacketNextWd` in 1: advance to the next 16-bit word.
- `PacketOut` out 16: current word, `{byte[2k+1], byte[2k]}`.
- `PacketFinal` out 8: byte 15 of the current frame.
- `Overflow` out 8: dropped-frame count; saturates at 0xFF; cleared only by reset.

## Operation
- Element intake:
  - `TraceNext` = `TraceAvail` && !`TraceNext`(previous cycle), so intake is at most one element every 2 cycles.
  - `TraceIn` is sampled in the strobe cycle.
  - Bits shift LSB-first into a 32-bit window, with the newest bits entering at the MSB.
- Sync detect:
  - The window equals 32'h7FFF_FFFF (bytes FF FF FF 7F) at a byte-aligned or unaligned position. Either case sets `sync`=1, byte count=0 and bit count=0, and discards any partial frame.
  - A sync word in mid-frame re-aligns the same way.
- Frame assembly (`sync`=1 only):
  - Bits accumulate into bytes, and 16 bytes form one frame.
  - On the 16th byte the frame is pushed to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the frame is dropped and `Overflow` is incremented.
- Timeout: when `SYNC_TIMEOUT`≠0, a counter increments per completed frame and clears on sync. When it reaches `SYNC_TIMEOUT`, `sync`=0 and assembly stops until the next sync word.
- Width change: any change of `width` clears `sync`, the window and the partial frame. The FIFO contents are kept.
- Read side:
  - `PacketNext` with `PacketAvail`=1 pops the head frame into the output register, loads `PacketFinal`, and sets the word index to "none".
  - While the index is "none", `PacketOut` holds 0x0000.
  - Each `PacketNextWd` advances none→0→1…→7 and saturates at 7.
  - `PacketNext` on an empty FIFO is ignored and the output register keeps its contents.

## Timing
- Reset values: `TraceNext`=0, `sync`=0, `PacketAvail`=0, `PacketOut`=0, `PacketFinal`=0, `Overflow`=0. FIFO is empty, window is 0, index is "none".
- Sync: `sync` rises at the edge that samples the element completing 7FFF_FFFF.
- Frame push: committed at the edge ending the cycle in which the 16th byte's last element is strobed. `PacketAvail` is 1 in the following cycle.
- Pop: occurs at the edge where `PacketNext` is sampled. `PacketFinal` is valid from the next cycle. `PacketAvail` reflects the new count the same cycle.
- Word advance: `PacketOut` updates in the cycle after `PacketNextWd` is sampled. `PacketNext` and `PacketNextWd` in the same cycle means `PacketNext` wins.
- Simultaneous push and pop on a full FIFO: both are accepted and there is no overflow. On an empty FIFO, a simultaneous push and `PacketNext` means the pop is ignored; the frame becomes available next cycle.
- `rst` low mid-frame or mid-read: all state returns to reset values at that edge.

## Structure
- Package `pack_collect_pkg`:
  - SYNC_WORD=32'h7FFF_FFFF
  - FRAME_BYTES=16
  - FRAME_WORDS=8
  - width encodings
  - a 128-bit frame typedef
- Sub-module `frame_fifo`: DEPTH×128-bit storage with wrapping read/write pointers, full/empty flags and same-cycle push/pop.

## Test plan
- 4-bit width: send junk FE 23, then sync FF FF FF 7F, then 00 10 01 11 … 07 68. Required: `PacketAvail`=0 before the last byte and 1 after it. After `PacketNext`, `PacketFinal`=0x68. Successive `PacketNextWd` give 1000, 1101, …, 6807, and a 9th advance still gives 6807.
- Repeat the first scenario at widths 00 and 01: identical words.
- 5 frames into `DEPTH`=4 with no reads: `Overflow`=1. The 4 frames read back are frames 1–4 in order.
- Sync word inserted after 7 bytes of a frame: the partial frame is discarded and the next 16 bytes form a correct frame.
- `SYNC_TIMEOUT`=2: after 2 frames with no sync, `sync`=0 and a 3rd frame is not pushed. A sync word restores `sync`=1.
- Width change mid-frame, and `rst` low mid-read: `sync`=0 and the partial frame is dropped. After reset, all outputs are 0.

Source files
------------

// File: rtl/pack_collect_pkg.sv
// pack_collect_pkg: shared constants, width encodings and frame type for the TPIU frame collector
package pack_collect_pkg;
  localparam logic [31:0] SYNC_WORD = 32'h7FFF_FFFF;
  localparam int FRAME_BYTES = 16;
  localparam int FRAME_WORDS = 8;
  typedef enum logic [1:0] {W1 = 2'b00, W2 = 2'b01, W4 = 2'b10, W4B = 2'b11} width_e;
  typedef logic [8*FRAME_BYTES-1:0] frame_t;
  function automatic logic [2:0] width_bits(input logic [1:0] w);
    return w == W1 ? 3'd1 : w == W2 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: DEPTH x 128-bit frame store with wrapping pointers and same-cycle push/pop
module frame_fifo import pack_collect_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  frame_t din,
  output frame_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  frame_t mem_q [DEPTH];
  frame_t mem_d [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wp_d = wp_q + {{AW{1'b0}}, do_push};
    rp_d = rp_q + {{AW{1'b0}}, do_pop};
    mem_d = mem_q;
    if (do_push) mem_d[wp_q[AW-1:0]] = din;
    dout = mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
endmodule

// File: rtl/pack_collect_fifo.sv
// pack_collect_fifo: locks onto TPIU sync, assembles 16-byte frames from 1/2/4-bit trace elements into a FIFO
module pack_collect_fifo import pack_collect_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int SYNC_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  width,
  input  logic [3:0]  TraceIn,
  input  logic        TraceAvail,
  output logic        TraceNext,
  output logic        sync,
  output logic        PacketAvail,
  input  logic        PacketNext,
  input  logic        PacketNextWd,
  output logic [15:0] PacketOut,
  output logic [7:0]  PacketFinal,
  output logic [7:0]  Overflow
);
  logic tn_q, tn_d, sync_q, sync_d, idx_v_q, idx_v_d;
  logic [1:0] width_q;
  logic [31:0] win_q, win_d, win_sh, to_q, to_d;
  frame_t frm_q, frm_d, frm_sh, out_q, out_d, head;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] ovf_q, ovf_d, bit_sum;
  logic [2:0] idx_q, idx_d, nb;
  logic push, pop, full, empty;
  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(frm_sh),
    .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    tn_d = TraceAvail && !tn_q;
    nb = width_bits(width);
    win_sh = width == W1 ? {TraceIn[0], win_q[31:1]} : width == W2 ? {TraceIn[1:0], win_q[31:2]} : {TraceIn, win_q[31:4]};
    frm_sh = width == W1 ? {TraceIn[0], frm_q[127:1]} : width == W2 ? {TraceIn[1:0], frm_q[127:2]} : {TraceIn, frm_q[127:4]};
    bit_sum = {1'b0, cnt_q} + {5'd0, nb};
    win_d = win_q;
    frm_d = frm_q;
    cnt_d = cnt_q;
    sync_d = sync_q;
    to_d = to_q;
    push = 1'b0;
    if (width != width_q) begin
      win_d = '0;
      frm_d = '0;
      cnt_d = '0;
      sync_d = 1'b0;
      to_d = '0;
    end else if (tn_d) begin
      win_d = win_sh;
      if (win_sh == SYNC_WORD) begin
        sync_d = 1'b1;
        frm_d = '0;
        cnt_d = '0;
        to_d = '0;
      end else if (sync_q) begin
        frm_d = frm_sh;
        cnt_d = bit_sum[6:0];
        push = bit_sum[7];
        if (bit_sum[7]) begin
          to_d = to_q + 32'd1;
          sync_d = !(SYNC_TIMEOUT != 0 && to_d == 32'(SYNC_TIMEOUT));
        end
      end
    end
    pop = PacketNext && !empty;
    ovf_d = push && full && !pop && ovf_q != 8'hFF ? ovf_q + 8'd1 : ovf_q;
    out_d = pop ? head : out_q;
    idx_v_d = pop ? 1'b0 : PacketNextWd ? 1'b1 : idx_v_q;
    idx_d = pop ? 3'd0 : PacketNextWd && idx_v_q && idx_q != 3'(FRAME_WORDS-1) ? idx_q + 3'd1 : idx_q;
  end
  always_ff @(posedge clk) begin
    width_q <= width;
    if (!rst) begin
      tn_q <= 1'b0;
      sync_q <= 1'b0;
      win_q <= '0;
      frm_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      ovf_q <= '0;
      out_q <= '0;
      idx_v_q <= 1'b0;
      idx_q <= '0;
    end else begin
      tn_q <= tn_d;
      sync_q <= sync_d;
      win_q <= win_d;
      frm_q <= frm_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      ovf_q <= ovf_d;
      out_q <= out_d;
      idx_v_q <= idx_v_d;
      idx_q <= idx_d;
    end
  end
  assign TraceNext = tn_d;
  assign sync = sync_q;
  assign PacketAvail = !empty;
  assign PacketOut = idx_v_q ? out_q[{idx_q, 4'b0} +: 16] : 16'h0000;
  assign PacketFinal = out_q[127:120];
  assign Overflow = ovf_q;
endmodule
